j_pit_timers: RTL and testbench



---
 rtl/j_pit_timers_if.sv | 20 ++
 rtl/j_pit_timers.sv | 71 +++++++
 tb/tb_j_pit_timers.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/j_pit_timers_if.sv
// j_pit_timers_if: JERRY I/O side of the dual PIT.
//   master: decoder/CPU side, drives cen, din, pit1w..pit4w, pit1r..pit4r
//   slave : timer block, drives tint1, tint2, dr_out, dr_oe
interface j_pit_timers_if;
  logic        cen;
  logic [15:0] din;
  logic        pit1w, pit2w, pit3w, pit4w;
  logic        pit1r, pit2r, pit3r, pit4r;
  logic        tint1, tint2;
  logic [15:0] dr_out;
  logic        dr_oe;
  modport master (
    output cen, din, pit1w, pit2w, pit3w, pit4w, pit1r, pit2r, pit3r, pit4r,
    input  tint1, tint2, dr_out, dr_oe
  );
  modport slave (
    input  cen, din, pit1w, pit2w, pit3w, pit4w, pit1r, pit2r, pit3r, pit4r,
    output tint1, tint2, dr_out, dr_oe
  );
endinterface

// File: rtl/j_pit_timers.sv
// j_pit_timers: dual prescaler/divider interval timer with one-cycle expiry pulses.
//   sys_clk : only clock
//   resetl  : asynchronous active-low reset
//   bus     : j_pit_timers_if.slave (write/read strobes, din, tint1/2, dr_out/dr_oe)
//   CW      : counter/reload width (1..16), readback zero-extended to 16 bits
//   JPIT_READBACK_EN : when defined, live counters are readable; otherwise dr_out/dr_oe are tied 0
module j_pit_timers #(
  parameter int CW = 16
) (
  input logic           sys_clk,
  input logic           resetl,
  j_pit_timers_if.slave bus
);
  logic [3:0]    w_pitw, r_pitw_q, w_edge;
  logic [CW-1:0] w_din;
  assign w_pitw = {bus.pit4w, bus.pit3w, bus.pit2w, bus.pit1w};
  assign w_edge = w_pitw & ~r_pitw_q;
  assign w_din  = bus.din[CW-1:0];
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) r_pitw_q <= '0;
    else         r_pitw_q <= w_pitw;
  end
  for (genvar t = 0; t < 2; t++) begin : g_tmr
    logic [CW-1:0] r_pre, r_div, r_pcnt, r_dcnt;
    logic          r_tint;
    logic          w_pe, w_de, w_run, w_pz, w_dz;
    assign w_pe  = w_edge[2*t];
    assign w_de  = w_edge[2*t+1];
    assign w_pz  = r_pcnt == '0;
    assign w_dz  = r_dcnt == '0;
    // any write edge to this timer pre-empts the tick, including a due expiry
    assign w_run = bus.cen && (r_div != '0) && !w_pe && !w_de;
    always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
        r_pre  <= '0;
        r_div  <= '0;
        r_pcnt <= '0;
        r_dcnt <= '0;
        r_tint <= 1'b0;
      end else begin
        r_tint <= w_run && w_pz && w_dz;
        if (w_pe) r_pre <= w_din;
        if (w_de) begin
          r_div  <= w_din;
          r_dcnt <= w_din;
          r_pcnt <= w_pe ? w_din : r_pre;
        end else if (w_pe) begin
          r_pcnt <= w_din;
        end else if (w_run) begin
          r_pcnt <= w_pz ? r_pre : r_pcnt - 1'b1;
          if (w_pz) r_dcnt <= w_dz ? r_div : r_dcnt - 1'b1;
        end
      end
    end
  end
  assign bus.tint1 = g_tmr[0].r_tint;
  assign bus.tint2 = g_tmr[1].r_tint;
`ifdef JPIT_READBACK_EN
  assign bus.dr_oe  = resetl && (bus.pit1r || bus.pit2r || bus.pit3r || bus.pit4r);
  assign bus.dr_out = !resetl   ? 16'h0000 :
                      bus.pit1r ? 16'(g_tmr[0].r_pcnt) :
                      bus.pit2r ? 16'(g_tmr[0].r_dcnt) :
                      bus.pit3r ? 16'(g_tmr[1].r_pcnt) :
                      bus.pit4r ? 16'(g_tmr[1].r_dcnt) : 16'h0000;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^{bus.pit1r, bus.pit2r, bus.pit3r, bus.pit4r};
  assign bus.dr_oe   = 1'b0;
  assign bus.dr_out  = 16'h0000;
`endif
endmodule

// File: tb/tb_j_pit_timers.sv
// tb_j_pit_timers: directed self-checking bench for j_pit_timers.
module tb_j_pit_timers;
  logic clk = 1'b0;
  logic resetl = 1'b0;
  int   n_chk = 0, n_fail = 0, cyc = 0, t1_ref = 0, t2_ref = 0, pulses = 0;
`ifdef JPIT_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  j_pit_timers_if bus();
  j_pit_timers #(.CW(16)) dut (.sys_clk(clk), .resetl(resetl), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask
  task automatic set_w(input int n, input logic v);
    case (n)
      1: bus.pit1w = v;
      2: bus.pit2w = v;
      3: bus.pit3w = v;
      default: bus.pit4w = v;
    endcase
  endtask
  task automatic wr(input int n, input int v);
    bus.din = 16'(v);
    set_w(n, 1'b1);
    tick();
    set_w(n, 1'b0);
  endtask
  initial begin
    bus.cen = 0; bus.din = 0;
    bus.pit1w = 0; bus.pit2w = 0; bus.pit3w = 0; bus.pit4w = 0;
    bus.pit1r = 0; bus.pit2r = 0; bus.pit3r = 0; bus.pit4r = 0;
    #1;
    chk("rst_tint1", bus.tint1, 0);
    chk("rst_tint2", bus.tint2, 0);
    chk("rst_dr_oe", bus.dr_oe, 0);
    chk("rst_dr_out", bus.dr_out, 0);
    tick(); tick();
    resetl = 1'b1;
    bus.cen = 1'b1;
    wr(1, 2); wr(2, 3); t1_ref = cyc;
    for (int k = 1; k <= 36; k++) begin
      tick();
      chk("t1_period", bus.tint1, int'((cyc - t1_ref) % 12 == 0));
    end
    wr(3, 0); wr(4, 4); t2_ref = cyc;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("t2_period", bus.tint2, int'((cyc - t2_ref) % 5 == 0));
      chk("t1_concurrent", bus.tint1, int'((cyc - t1_ref) % 12 == 0));
    end
    while ((cyc - t1_ref) % 12 != 11) tick();
    bus.din = 16'd1; bus.pit2w = 1'b1;
    tick();
    bus.pit2w = 1'b0;
    chk("wr_vs_exp", bus.tint1, 0);
    t1_ref = cyc;
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk("t1_restart", bus.tint1, int'((cyc - t1_ref) % 6 == 0));
    end
    bus.cen = 1'b0;
    wr(2, 3);
    for (int k = 1; k <= 48; k++) begin
      bus.cen = k[0];
      tick();
      chk("t1_gated", bus.tint1, int'(k == 23 || k == 47));
    end
    bus.cen = 1'b1;
    wr(2, 0);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      pulses += int'(bus.tint1);
    end
    chk("t1_off_pulses", pulses, 0);
    bus.pit1r = 1'b1; #1;
    chk("t1_off_pcnt", bus.dr_out, RB ? 2 : 0);
    bus.pit1r = 1'b0;
    bus.cen = 1'b0;
    tick();
    bus.din = 16'd5; bus.pit3w = 1'b1; tick();
    bus.din = 16'd6; tick();
    bus.din = 16'd7; tick();
    bus.din = 16'd8; tick();
    bus.pit3w = 1'b0;
    bus.pit3r = 1'b1; #1;
    chk("pre2_edge_rd", bus.dr_out, RB ? 5 : 0);
    bus.pit3r = 1'b0;
    wr(4, 1);
    bus.cen = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("t2_edge_period", bus.tint2, int'(k == 12));
    end
    bus.cen = 1'b0;
    wr(1, 7); wr(4, 2);
    bus.pit1r = 1'b1; bus.pit4r = 1'b1; #1;
    chk("rd_prio_out", bus.dr_out, RB ? 7 : 0);
    chk("rd_prio_oe", bus.dr_oe, int'(RB));
    bus.pit1r = 1'b0; #1;
    chk("rd_dcnt2", bus.dr_out, RB ? 2 : 0);
    bus.pit3r = 1'b1; #1;
    chk("rd_pcnt2_prio", bus.dr_out, RB ? 5 : 0);
    bus.pit3r = 1'b0; bus.pit4r = 1'b0; #1;
    chk("rd_idle_out", bus.dr_out, 0);
    chk("rd_idle_oe", bus.dr_oe, 0);
    tick();
    bus.cen = 1'b1;
    wr(1, 2); wr(2, 3);
    repeat (11) tick();
    resetl = 1'b0; #1;
    chk("mid_rst_tint1", bus.tint1, 0);
    chk("mid_rst_tint2", bus.tint2, 0);
    chk("mid_rst_oe", bus.dr_oe, 0);
    chk("mid_rst_out", bus.dr_out, 0);
    tick();
    chk("mid_rst_no_pulse", bus.tint1, 0);
    tick();
    resetl = 1'b1;
    bus.pit2r = 1'b1; #1;
    chk("post_rst_dcnt1", bus.dr_out, 0);
    chk("post_rst_oe", bus.dr_oe, int'(RB));
    bus.pit2r = 1'b0;
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      pulses += int'(bus.tint1) + int'(bus.tint2);
    end
    chk("post_rst_pulses", pulses, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
